// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the
// instruction-fetch requester and the data (mem-stage) requester.
// Data has fixed priority; read data returns one cycle after the grant and
// is steered to whichever requester owned that read.
// Optional build macro ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive
// data grants while fetch is waiting, fetch wins one cycle.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_port_arbiter #(
  parameter int ADDR_W       = `ADDR_WIDTH,
  parameter int DATA_W       = `DATA_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // data requester (mem stage)
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [3:0]        d_sel_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  // fetch requester (pc_reg / if stage)
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              if_stall_o,
  // RAM port
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic [3:0]        ram_sel_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  // Owner of the read whose data arrives on ram_rdata_i this cycle.
  localparam logic [1:0] ST_NONE    = 2'd0;
  localparam logic [1:0] ST_DATA_RD = 2'd1;
  localparam logic [1:0] ST_INST_RD = 2'd2;

  // The starve counter is 3 bits wide, so the limit must fit in it.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..7");
  end

  logic [1:0] state_q, state_d;
  logic       d_gnt, i_gnt, fetch_force;

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;

  assign fetch_force = d_req_i & i_req_i & (starve_q == 3'(STARVE_LIMIT));

  // Count data grants that made a waiting fetch lose; saturate at 7.
  always_comb begin
    starve_d = starve_q;
    if (!i_req_i || i_gnt)
      starve_d = 3'd0;
    else if (d_gnt && starve_q != 3'd7)
      starve_d = starve_q + 3'd1;
  end

  // Starve counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) starve_q <= 3'd0;
    else       starve_q <= starve_d;
  end
`else
  assign fetch_force = 1'b0;
`endif

  // Grants are masked during reset so nothing reaches the RAM or the owner FSM.
  always_comb begin
    d_gnt = ~rst_i & d_req_i & ~fetch_force;
    i_gnt = ~rst_i & i_req_i & ~d_gnt;
  end

  // Next owner: only granted reads produce a return next cycle.
  always_comb begin
    state_d = ST_NONE;
    if (d_gnt && !d_we_i) state_d = ST_DATA_RD;
    else if (i_gnt)       state_d = ST_INST_RD;
  end

  // Owner register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_NONE;
    else       state_q <= state_d;
  end

  // Drive the RAM bus from the winner, steer read data to the owner.
  always_comb begin
    d_gnt_o     = d_gnt;
    i_gnt_o     = i_gnt;
    if_stall_o  = ~rst_i & i_req_i & ~i_gnt;
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_sel_o   = 4'h0;
    if (d_gnt) begin
      ram_ce_o    = 1'b1;
      ram_we_o    = d_we_i;
      ram_addr_o  = d_addr_i;
      ram_wdata_o = d_wdata_i;
      ram_sel_o   = d_sel_i;
    end else if (i_gnt) begin
      ram_ce_o    = 1'b1;
      ram_addr_o  = i_addr_i;
      ram_sel_o   = 4'hF;
    end
    // A read outstanding when reset arrives is dropped, not returned.
    d_rvalid_o = ~rst_i & (state_q == ST_DATA_RD);
    i_rvalid_o = ~rst_i & (state_q == ST_INST_RD);
    d_rdata_o  = d_rvalid_o ? ram_rdata_i : '0;
    i_rdata_o  = i_rvalid_o ? ram_rdata_i : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a RAM model answers the DUT's bus, a
// transaction-level reference (golden memory + pending-return record +
// fetch-wait streak) predicts every output each cycle, and directed
// scenarios pin literal values.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req, d_we, i_req;
  logic [31:0] d_addr, d_wdata, i_addr;
  logic [3:0]  d_sel;
  logic        d_gnt, d_rvalid, i_gnt, i_rvalid, if_stall;
  logic [31:0] d_rdata, i_rdata;
  logic        ram_ce, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_i(rst),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_sel_i(d_sel), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt), .i_rvalid_o(i_rvalid),
    .i_rdata_o(i_rdata), .if_stall_o(if_stall),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_sel_o(ram_sel), .ram_rdata_i(ram_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM seen by the DUT ----------------
  logic [31:0] ram  [256];
  logic [31:0] gmem [256];   // reference copy, updated only by the model

  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel[b]) ram[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= $urandom;
    end else if (ram_ce) begin
      ram_rdata <= ram[ram_addr[9:2]];
    end else begin
      ram_rdata <= $urandom;   // stale junk must never leak out
    end
  end

  // ---------------- reference model ----------------
  int          pend_kind = 0;  // 0 nothing, 1 data read, 2 fetch read
  logic [31:0] pend_val  = '0;
  int          streak    = 0;  // data wins in a row while fetch waited
  bit          hold_d = 0, hold_i = 0;

  function automatic void want_grants(output bit dg, output bit ig);
    bit fetch_turn;
`ifdef ARB_STARVE_GUARD_EN
    fetch_turn = d_req && i_req && (streak == LIMIT);
`else
    fetch_turn = 0;
`endif
    dg = !rst && d_req && !fetch_turn;
    ig = !rst && i_req && !dg;
  endfunction

  always @(posedge clk) begin
    bit dg, ig;
    want_grants(dg, ig);
    if (rst) begin
      pend_kind = 0;
      streak    = 0;
    end else begin
      if (dg && d_we) begin
        for (int b = 0; b < 4; b++)
          if (d_sel[b]) gmem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
        pend_kind = 0;
      end else if (dg) begin
        pend_kind = 1;
        pend_val  = gmem[d_addr[9:2]];
      end else if (ig) begin
        pend_kind = 2;
        pend_val  = gmem[i_addr[9:2]];
      end else begin
        pend_kind = 0;
      end
      if (!i_req || ig) streak = 0;
      else if (dg && streak < 7) streak++;
    end
    hold_d = !rst && d_req && !dg;
    hold_i = !rst && i_req && !ig;
  end

  // Compare every output against the reference, mid-cycle.
  always @(negedge clk) begin
    bit dg, ig;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_sel;
    bit e_ce, e_we, e_drv, e_irv;
    want_grants(dg, ig);
    e_ce = dg || ig;
    e_we = dg && d_we;
    e_addr  = dg ? d_addr  : (ig ? i_addr : 32'h0);
    e_wdata = dg ? d_wdata : 32'h0;
    e_sel   = dg ? d_sel   : (ig ? 4'hF : 4'h0);
    e_drv = !rst && pend_kind == 1;
    e_irv = !rst && pend_kind == 2;
    chk("d_gnt",     d_gnt,     dg);
    chk("i_gnt",     i_gnt,     ig);
    chk("if_stall",  if_stall,  !rst && i_req && !ig);
    chk("ram_ce",    ram_ce,    e_ce);
    chk("ram_we",    ram_we,    e_we);
    chk("ram_addr",  ram_addr,  e_addr);
    chk("ram_wdata", ram_wdata, e_wdata);
    chk("ram_sel",   ram_sel,   e_sel);
    chk("d_rvalid",  d_rvalid,  e_drv);
    chk("i_rvalid",  i_rvalid,  e_irv);
    chk("d_rdata",   d_rdata,   e_drv ? pend_val : 32'h0);
    chk("i_rdata",   i_rdata,   e_irv ? pend_val : 32'h0);
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_req = 0; d_we = 0; i_req = 0;
  endtask

  initial begin
    bit exp_d;
    for (int k = 0; k < 256; k++) begin
      ram[k]  = $urandom;
      gmem[k] = ram[k];
    end
    ram[0]    = 32'h00000013; ram[1]    = 32'h00100093; ram[2] = 32'h00200113;
    ram[4]    = 32'h00400193; ram[8'h40] = 32'hCAFE0100; ram[8'h80] = 32'h12345678;
    gmem[0]   = 32'h00000013; gmem[1]   = 32'h00100093; gmem[2] = 32'h00200113;
    gmem[4]   = 32'h00400193; gmem[8'h40] = 32'hCAFE0100; gmem[8'h80] = 32'h12345678;
    ram_rdata = '0;

    // reset held 2 cycles with both requesting
    rst = 1; d_req = 1; d_we = 0; d_addr = 32'h100; d_wdata = 0; d_sel = 4'hF;
    i_req = 1; i_addr = 32'h0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      @(negedge clk);
      chk("rst_ce", ram_ce, 0);
      chk("rst_dgnt", d_gnt, 0);
      chk("rst_stall", if_stall, 0);
    end
    cyc(); rst = 0; idle();
    @(negedge clk);
    chk("post_rst_drv", d_rvalid, 0);
    chk("post_rst_irv", i_rvalid, 0);

    // fetch only, three sequential words
    cyc(); i_req = 1; i_addr = 32'h0;
    @(negedge clk); chk("f0_gnt", i_gnt, 1); chk("f0_stall", if_stall, 0);
    cyc(); i_addr = 32'h4;
    @(negedge clk); chk("f1_rv", i_rvalid, 1); chk("f1_data", i_rdata, 32'h00000013);
    cyc(); i_addr = 32'h8;
    @(negedge clk); chk("f2_data", i_rdata, 32'h00100093); chk("f2_gnt", i_gnt, 1);
    cyc(); idle();
    @(negedge clk); chk("f3_rv", i_rvalid, 1); chk("f3_data", i_rdata, 32'h00200113);

    // collision: data wins, fetch retries
    cyc(); d_req = 1; d_we = 0; d_addr = 32'h100; d_sel = 4'hF; i_req = 1; i_addr = 32'h10;
    @(negedge clk); chk("col_dgnt", d_gnt, 1); chk("col_igt", i_gnt, 0); chk("col_stall", if_stall, 1);
    cyc(); d_req = 0;
    @(negedge clk);
    chk("col_drv", d_rvalid, 1); chk("col_ddata", d_rdata, 32'hCAFE0100); chk("col_igt2", i_gnt, 1);
    cyc(); idle();
    @(negedge clk); chk("col_irv", i_rvalid, 1); chk("col_idata", i_rdata, 32'h00400193);

    // partial write, then read back
    cyc(); d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_sel = 4'b0011;
    @(negedge clk); chk("wr_we", ram_we, 1); chk("wr_sel", ram_sel, 4'b0011);
    cyc(); idle();
    @(negedge clk); chk("wr_no_drv", d_rvalid, 0); chk("wr_no_irv", i_rvalid, 0);
    cyc(); d_req = 1; d_we = 0; d_sel = 4'hF;
    cyc(); idle();
    @(negedge clk); chk("wr_readback", d_rdata, 32'h1234BEEF);

    // both requesting for 10 cycles
    cyc(); d_req = 1; d_we = 0; d_addr = 32'h100; i_req = 1; i_addr = 32'h10;
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_d = (k % 5) != 4;
`else
      exp_d = 1;
`endif
      @(negedge clk);
      chk("starve_dgnt", d_gnt, exp_d);
      chk("starve_igt",  i_gnt, !exp_d);
      if (k < 9) cyc();
    end
    cyc(); idle();

    // reset while a data read is outstanding
    cyc(); d_req = 1; d_we = 0; d_addr = 32'h100;
    @(negedge clk); chk("rmr_gnt", d_gnt, 1);
    cyc(); rst = 1; idle();
    @(negedge clk); chk("rmr_drv", d_rvalid, 0);
    cyc(); rst = 0;
    @(negedge clk); chk("rmr_drv2", d_rvalid, 0); chk("rmr_irv2", i_rvalid, 0);

    // randomized traffic; denied requesters hold their request stable
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst = ($urandom_range(199) == 0);
      if (!hold_d) begin
        d_req   = ($urandom_range(99) < 55);
        d_we    = ($urandom_range(2) == 0);
        d_addr  = 32'($urandom_range(255)) << 2;
        d_wdata = $urandom;
        d_sel   = 4'($urandom_range(15));
      end
      if (!hold_i) begin
        i_req  = ($urandom_range(99) < 65);
        i_addr = 32'($urandom_range(255)) << 2;
      end
    end
    cyc(); idle(); rst = 0;
    cyc();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
